button_conditioner: RTL and testbench
=====================================

# button_conditioner

Conditions the five raw front-panel pushbuttons before they reach the menu/control FSM. Each button gets a two-flop synchronizer, a counter-based debouncer, a single-cycle press pulse and an optional hold-to-repeat pulse train. The block sits directly upstream of the menu controller, so that controller sees only clean, single-cycle press events on `CLK`.

## Interface
- `DEB_CYCLES`, default 2_000_000: consecutive stable cycles required to accept a level change (20 ms at 100 MHz); minimum 2.
- `HOLD_CYCLES`, default 50_000_000: cycles a press must be held before the first auto-repeat pulse.
- `REPEAT_CYCLES`, default 10_000_000: spacing between subsequent auto-repeat pulses.
- `REPEAT_MASK`, default 5'b00011: per-bit enable for auto-repeat; the default enables arriba and abajo only.
- `CLK`, input, 1 bit: system clock; the only clock in the block.
- `RST`, input, 1 bit: reset; synchronous and active-high.
- `B_in`, input, 5 bits: raw, asynchronous button levels, 1 = pressed. Bit order: 0 arriba, 1 abajo, 2 izquierda, 3 derecha, 4 centro.
- `L_out`, output, 5 bits: debounced button levels.
- `P_out`, output, 5 bits: one-cycle press/repeat pulses, registered.

## Operation
- Each bit is an independent channel. There is no cross-button priority or lockout.
- **Synchronizer:** two flops per bit, giving sample `s`.
- **Debounce:**
  - The counter `dc` increments on every cycle where `s != L`.
  - `dc` clears on any cycle where `s == L`.
  - When `dc == DEB_CYCLES-1` and `s != L`, `L` toggles on the next edge and `dc` clears.
  - Any glitch shorter than `DEB_CYCLES` cycles produces no change on `L`.
- **Per-channel FSM:**
  - `IDLE`: `L` rising → pulse `P`, clear `hc`, go to `ARMED`.
  - `ARMED`: `hc` counts each cycle. If `L` falls → `IDLE`. If `hc == HOLD_CYCLES-1` and the channel's `REPEAT_MASK` bit is set → pulse `P`, clear `hc`, go to `REPEAT`.
  - `REPEAT`: `hc` counts each cycle. If `L` falls → `IDLE`. If `hc == REPEAT_CYCLES-1` → pulse `P`, clear `hc`.
  - When the `REPEAT_MASK` bit is clear, `ARMED` stays in `ARMED` until `L` falls, with no further pulses.
- Release never pulses.
- **Counter widths:**
  - `dc` is `$clog2(DEB_CYCLES)` bits.
  - `hc` is `$clog2(max(HOLD_CYCLES, REPEAT_CYCLES))` bits.
  - Neither counter may wrap: each is cleared by its terminal condition before overflow.

## Timing
- **Reset:** `RST` high at an edge clears the sync flops, `dc`, `hc` and `L_out`, forces the FSM to `IDLE`, and drives `P_out = 0` on the following cycle.
- **Press latency:** a raw edge sampled at edge t gives `L` = 1 and `P` = 1 at edge t+2+`DEB_CYCLES`. Allow ±1 cycle for the asynchronous input arriving relative to `CLK`.
- **Release latency:** `L` falls at the same latency as a press. The FSM is back in `IDLE` one cycle later.
- **Repeat timing:** with the first pulse at cycle T, repeat pulses occur at T+`HOLD_CYCLES`, then at T+`HOLD_CYCLES`+k·`REPEAT_CYCLES` for k = 1, 2, …
- **Pulse width:** `P` is high for exactly one cycle per event. There are never two consecutive high cycles on one bit.
- **Held through reset:** a button held while `RST` deasserts is treated as a new press, pulsing at 2+`DEB_CYCLES` cycles after reset release.
- **Reset mid-operation:** `RST` mid-debounce or mid-repeat aborts with no pulse.
- **Release on a repeat boundary:** if `L` falls in the same cycle that `hc` reaches its terminal count, the release wins and no pulse is issued.
- **Simultaneous presses:** several buttons may pulse in the same cycle. `P_out` simply carries multiple bits high.

## Structure
- One sub-module, `button_channel`, holds the synchronizer, debouncer and FSM for a single bit. It takes parameters `DEB_CYCLES`, `HOLD_CYCLES`, `REPEAT_CYCLES` and `REPEAT_EN`.
- `button_conditioner` instantiates `button_channel` five times with a generate loop, passing `REPEAT_MASK[i]` as `REPEAT_EN`.
- The shared package/include holds the button bit-index constants (`BTN_ARRIBA`=0 … `BTN_CENTRO`=4) and the default timing constants, so the menu controller uses the same indices.

## Test plan
All scenarios run with `DEB_CYCLES`=4, `HOLD_CYCLES`=20, `REPEAT_CYCLES`=8.
- **Clean press/release on bit 4:** raise `B_in[4]` at edge 10 → `L_out[4]`=1 and `P_out`=5'b10000 for exactly one cycle at edge 16. Release at edge 40 → `L_out[4]`=0 at edge 46, with no pulse.
- **Glitch rejection:** a 3-cycle high pulse on `B_in[2]` → `L_out` and `P_out` stay 0. A 4-cycle stable high is accepted.
- **Auto-repeat on bit 0:** hold `B_in[0]` for 60 cycles → pulses at T, T+20, T+28, T+36, … while held. Bit 3 held for 60 cycles under the default mask gives a single pulse.
- **Simultaneous presses:** bits 0 and 1 pressed in the same cycle → `P_out`=5'b00011 in one cycle, with identical repeat trains.
- **Reset mid-hold:** assert `RST` at T+15 → all outputs 0 on the next cycle. Keep the button held and release `RST` → a new pulse 6 cycles after release.
- **Release at the repeat terminal count:** drop `L` exactly when `hc` reaches `REPEAT_CYCLES-1` → no pulse, FSM returns to `IDLE`.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared button indices, default timing constants and per-channel FSM states.
// The menu controller imports this package so both sides agree on the bit order.
package button_conditioner_pkg;

  localparam int NUM_BTNS      = 5;
  localparam int BTN_ARRIBA    = 0;
  localparam int BTN_ABAJO     = 1;
  localparam int BTN_IZQUIERDA = 2;
  localparam int BTN_DERECHA   = 3;
  localparam int BTN_CENTRO    = 4;

  localparam int DEF_DEB_CYCLES    = 2_000_000;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  localparam logic [NUM_BTNS-1:0] DEF_REPEAT_MASK = 5'b00011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_REPEAT = 2'd2
  } chan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width that holds values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton: two-flop synchronizer, counter debouncer and press/repeat FSM.
// The press pulse lines up with the debounced level rising on the same edge.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int   DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int   HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int   REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter logic REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int DC_W = cnt_width(DEB_CYCLES);
  localparam int HC_W = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [DC_W-1:0] DC_LAST   = DC_W'(DEB_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic [DC_W-1:0] dc;
  logic [HC_W-1:0] hc;
  chan_state_t     state;
  logic            differ;
  logic            deb_done;
  logic            rise;

  assign differ   = (sync_p1 != level);
  assign deb_done = differ && (dc == DC_LAST);
  assign rise     = deb_done && !level;

  // Stage p0/p1: metastability filter for the asynchronous button level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      dc    <= '0;
      level <= 1'b0;
    end else begin
      if (!differ || deb_done) begin
        dc <= '0;
      end else begin
        dc <= dc + 1'b1;
      end
      if (deb_done) begin
        level <= ~level;
      end
    end
  end

  // Press/repeat FSM; the registered level is checked first so a release
  // landing on a terminal count suppresses the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hc    <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          hc <= '0;
          if (rise) begin
            pulse <= 1'b1;
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!level) begin
            hc    <= '0;
            state <= ST_IDLE;
          end else if (REPEAT_EN && (hc == HOLD_LAST)) begin
            pulse <= 1'b1;
            hc    <= '0;
            state <= ST_REPEAT;
          end else if (hc != HOLD_LAST) begin
            // Saturates when repeat is disabled so the count never wraps.
            hc <= hc + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!level) begin
            hc    <= '0;
            state <= ST_IDLE;
          end else if (hc == REP_LAST) begin
            pulse <= 1'b1;
            hc    <= '0;
          end else begin
            hc <= hc + 1'b1;
          end
        end
        default: begin
          hc    <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Five independent front-panel button channels feeding the menu controller.
// Each bit gets its own debouncer and press/repeat FSM; no cross-button lockout.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter logic [NUM_BTNS-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_BTNS-1:0] B_in,
  output logic [NUM_BTNS-1:0] L_out,
  output logic [NUM_BTNS-1:0] P_out
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    button_channel #(
      .DEB_CYCLES   (DEB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (REPEAT_MASK[i])
    ) u_chan (
      .clk    (CLK),
      .rst    (RST),
      .btn_raw(B_in[i]),
      .level  (L_out[i]),
      .pulse  (P_out[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// every cycle compared against an event-time reference model.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam logic [4:0] MASK = 5'b00011;

  logic       CLK;
  logic       RST;
  logic [4:0] B_in;
  logic [4:0] L_out;
  logic [4:0] P_out;

  button_conditioner #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .REPEAT_MASK  (MASK)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .B_in (B_in),
    .L_out(L_out),
    .P_out(P_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: sync pipeline, debounced level, mismatch run
  // length, and press time of the current hold for arithmetic repeat timing.
  logic [4:0] m_s1, m_s2, m_L, m_P, m_held;
  int         m_run [5];
  int         m_T   [5];
  int         cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic void model_edge(input logic [4:0] b, input logic r);
    logic [4:0] nxt_L;
    logic       tg;
    int         age;
    cyc++;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_L = '0; m_P = '0; m_held = '0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      return;
    end
    nxt_L = m_L;
    for (int i = 0; i < 5; i++) begin
      m_P[i] = 1'b0;
      if (m_s2[i] != m_L[i]) m_run[i]++;
      else m_run[i] = 0;
      tg = (m_run[i] == DEB);
      if (tg) begin
        m_run[i] = 0;
        nxt_L[i] = ~m_L[i];
      end
      if (tg && !m_L[i]) begin
        m_P[i] = 1'b1; m_held[i] = 1'b1; m_T[i] = cyc;
      end else if (m_held[i]) begin
        if (!m_L[i]) m_held[i] = 1'b0;
        else if (MASK[i]) begin
          age = cyc - m_T[i];
          if (age == HOLD || (age > HOLD && (age - HOLD) % REP == 0)) m_P[i] = 1'b1;
        end
      end
    end
    m_L  = nxt_L;
    m_s2 = m_s1;
    m_s1 = b;
  endfunction

  task automatic step(input logic [4:0] b, input logic r);
    B_in = b;
    RST  = r;
    @(posedge CLK);
    model_edge(b, r);
    #1;
    chk("level", 32'(L_out), 32'(m_L));
    chk("pulse", 32'(P_out), 32'(m_P));
  endtask

  // Steps with b held until P_out[bn] is seen; lat = 20 if it never shows.
  task automatic wait_pulse(input logic [4:0] b, input int bn, output int lat);
    lat = 20;
    for (int k = 1; k <= 20; k++) begin
      step(b, 1'b0);
      if (P_out[bn]) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, cnt, first, second, last;
    int rem [5];
    logic [4:0] rb;
    logic rr;
    B_in = '0;
    RST  = 1'b1;

    // Reset
    for (int k = 0; k < 3; k++) step(5'b0, 1'b1);
    chk("rst_L", 32'(L_out), 32'd0);
    chk("rst_P", 32'(P_out), 32'd0);
    for (int k = 0; k < 3; k++) step(5'b0, 1'b0);

    // Clean press / release on centro
    wait_pulse(5'b10000, 4, lat);
    chk("press_lat", 32'(lat), 32'd6);
    chk("press_pout", 32'(P_out), 32'h10);
    chk("press_lvl", 32'(L_out[4]), 32'd1);
    cnt = 0;
    for (int k = 0; k < 24; k++) begin
      step(5'b10000, 1'b0);
      if (P_out[4]) cnt++;
    end
    chk("centro_single", 32'(cnt), 32'd0);
    lat = 20; cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      step(5'b0, 1'b0);
      if (P_out[4]) cnt++;
      if (!L_out[4]) begin lat = k; break; end
    end
    chk("release_lat", 32'(lat), 32'd6);
    chk("release_nopulse", 32'(cnt), 32'd0);
    for (int k = 0; k < 4; k++) step(5'b0, 1'b0);

    // Glitch rejection then acceptance on izquierda
    cnt = 0;
    for (int k = 0; k < 3; k++) step(5'b00100, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(5'b0, 1'b0);
      if (P_out != 0 || L_out != 0) cnt++;
    end
    chk("glitch_reject", 32'(cnt), 32'd0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step(5'b00100, 1'b0);
      if (P_out[2]) cnt++;
    end
    for (int k = 0; k < 14; k++) begin
      step(5'b0, 1'b0);
      if (P_out[2]) cnt++;
    end
    chk("glitch_accept", 32'(cnt), 32'd1);

    // Auto-repeat on arriba for 60 cycles
    cnt = 0; first = 0; second = 0; last = 0;
    for (int k = 1; k <= 60; k++) begin
      step(5'b00001, 1'b0);
      if (P_out[0]) begin
        cnt++;
        if (cnt == 1) first = k;
        if (cnt == 2) second = k;
        if (cnt == 3) last = k;
      end
    end
    chk("rep_count", 32'(cnt), 32'd6);
    chk("rep_hold_gap", 32'(second - first), 32'(HOLD));
    chk("rep_period", 32'(last - second), 32'(REP));
    for (int k = 0; k < 12; k++) step(5'b0, 1'b0);

    // derecha is not in the repeat mask: single pulse only
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step(5'b01000, 1'b0);
      if (P_out[3]) cnt++;
    end
    for (int k = 0; k < 12; k++) begin
      step(5'b0, 1'b0);
      if (P_out[3]) cnt++;
    end
    chk("derecha_single", 32'(cnt), 32'd1);

    // Simultaneous arriba + abajo
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      step(5'b00011, 1'b0);
      if (P_out == 5'b00011) cnt++;
    end
    chk("simul_pulses", 32'(cnt), 32'd5);
    for (int k = 0; k < 12; k++) step(5'b0, 1'b0);

    // Reset in the middle of a hold, button kept pressed through reset
    wait_pulse(5'b00001, 0, lat);
    chk("hold_press_lat", 32'(lat), 32'd6);
    for (int k = 0; k < 14; k++) step(5'b00001, 1'b0);
    step(5'b00001, 1'b1);
    chk("midrst_P", 32'(P_out), 32'd0);
    chk("midrst_L", 32'(L_out), 32'd0);
    step(5'b00001, 1'b1);
    wait_pulse(5'b00001, 0, lat);
    chk("rst_release_lat", 32'(lat), 32'd6);
    for (int k = 0; k < 12; k++) step(5'b0, 1'b0);

    // Release arriving exactly on the repeat terminal count (abajo)
    wait_pulse(5'b00010, 1, lat);
    for (int k = 0; k < 21; k++) step(5'b00010, 1'b0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(5'b0, 1'b0);
      if (P_out[1]) cnt++;
    end
    chk("term_release_nopulse", 32'(cnt), 32'd0);
    wait_pulse(5'b00010, 1, lat);
    chk("term_repress_lat", 32'(lat), 32'd6);
    for (int k = 0; k < 12; k++) step(5'b0, 1'b0);

    // Random button activity with occasional resets
    rb = '0;
    for (int i = 0; i < 5; i++) rem[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 5; i++) begin
        if (rem[i] == 0) begin
          rb[i]  = $urandom_range(0, 1);
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 70);
        end
        rem[i]--;
      end
      rr = ($urandom_range(0, 399) == 0);
      step(rb, rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
